matrix_scan: RTL and testbench
==============================

MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: CLOCK_50 cycles per row slot (1 kHz row rate, 200 Hz frame at 50 MHz); legal range 2 and up.
REQ-002 Parameter BLINK_BIT, default 24: bit of the free-running blink counter that gates the cursor overlay.
REQ-003 CLOCK_50  in  1: single clock, all logic on the rising edge.
REQ-004 rst  in  1: reset, synchronous, active-high.
REQ-005 en  in  1: display enable; low blanks the outputs.
REQ-006 wr_en  in  1: frame-buffer write strobe, one pixel per cycle.
REQ-007 wr_row  in  3: write/read row index, legal 0..4.
REQ-008 wr_col  in  3: write/read column index, legal 0..6.
REQ-009 wr_data  in  1: pixel value written.
REQ-010 clr  in  1: clears the whole frame buffer.
REQ-011 cur_en  in  1: enables the blinking cursor overlay.
REQ-012 cur_row  in  3 and cur_col  in  3: cursor position.
REQ-013 rd_data  out  1: combinational value of frame[wr_row][wr_col]; 0 when the index is out of range.
REQ-014 row  out  5: one-hot row select, active-high.
REQ-015 column  out  7: column data for the selected row, active-high.
REQ-016 frame_done  out  1: one-cycle pulse when row 4's slot ends.

Function
REQ-017 Storage: 5x7 frame buffer; bit [r][c] is the pixel at row r, column c.
REQ-018 Writes: wr_en with in-range indices updates the pixel at the clock edge; out-of-range writes are ignored.
REQ-019 clr: zeroes all 35 bits in one cycle and takes priority over a wr_en in the same cycle.
REQ-020 Prescaler: counts 0..SCAN_DIV-1 and wraps; tick is asserted at count SCAN_DIV-1.
REQ-021 Scan index: 0..4, advances on tick, 4 wraps to 0.
REQ-022 frame_done: asserted for the cycle in which the scan index wraps from 4 to 0.
REQ-023 Scan states: BLANK and DRIVE.
  - Each row slot starts with exactly one BLANK cycle: row=0, column=0 (anti-ghosting).
  - All remaining SCAN_DIV-1 cycles of the slot are DRIVE.
REQ-024 Outputs are registered. In DRIVE: row = onehot(scan index); column = frame[scan index] OR the cursor mask.
REQ-025 Cursor mask: onehot(cur_col) when cur_en=1, cur_row equals the scan index, blink counter bit BLINK_BIT=1, and both cursor indices are in range; otherwise 0.
REQ-026 Blink counter: 26-bit, free-running, increments every cycle and is independent of en.
REQ-027 Write latency: a pixel written in the cycle before a row's DRIVE phase begins appears in that slot. Otherwise it appears no later than the next slot of that row.
REQ-028 en=0:
  - row, column and frame_done are 0.
  - Prescaler and scan index are held at 0.
  - Frame buffer is retained; writes and clr still take effect.
REQ-029 en rising: scanning restarts with the BLANK cycle of row 0.

Reset
REQ-030 rst=1 at a clock edge sets:
  - row=0, column=0, frame_done=0;
  - prescaler=0, scan index=0, state=BLANK;
  - blink counter=0, frame buffer all zero.
REQ-031 rst takes priority over clr, wr_en and en, including in the middle of a row slot.

Structure
REQ-032 A shared package holds:
  - constants N_ROWS=5, N_COLS=7;
  - the row/column index widths;
  - the scan-state typedef.
REQ-033 One sub-module, matrix_prescaler, produces tick from SCAN_DIV; it has a synchronous clear driven by rst or !en.
REQ-034 The frame buffer is flip-flops (35 bits), not inferred RAM.

Verification (SCAN_DIV=4, BLINK_BIT=2)
REQ-035 Write (0,0)=1 and (4,6)=1, en=1 → row 0 slot: row=00001, column=0000001. Row 4 slot: row=10000, column=1000000. Other rows: column=0.
REQ-036 Each slot → exactly 1 BLANK cycle with row=0, then 3 DRIVE cycles; frame_done pulses once every 20 cycles.
REQ-037 Full frame written, then clr and wr_en (1,1,1) in the same cycle → all columns 0 on the next frame; rd_data at (1,1)=0.
REQ-038 Write (5,0) and (0,7) → buffer unchanged; rd_data=0 for both indices.
REQ-039 cur_en=1, cursor (2,3), empty frame → row 2 DRIVE shows column=0001000 while blink bit=1 and 0 while blink bit=0.
REQ-040 Cases:
  - rst asserted in the middle of a row 3 slot → next cycle all outputs 0 and buffer cleared.
  - en low for 10 cycles, then high → outputs 0 throughout, then the BLANK cycle of row 0.

Source files
------------

// File: rtl/matrix_scan_pkg.sv
// rtl/matrix_scan_pkg.sv - shared constants, index widths and scan-state type for the LED matrix scanner
package matrix_scan_pkg;

  localparam int N_ROWS = 5;
  localparam int N_COLS = 7;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int BLINK_W = 26;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [N_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    return N_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/matrix_prescaler.sv
// rtl/matrix_prescaler.sv - row-slot prescaler, counts 0..SCAN_DIV-1 and flags the last count
module matrix_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// rtl/matrix_scan.sv - 5x7 LED matrix scanner with flip-flop frame buffer and blinking cursor
module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_BIT = 24
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic              wr_data,
  input  logic              clr,
  input  logic              cur_en,
  input  logic [ROW_W-1:0]  cur_row,
  input  logic [COL_W-1:0]  cur_col,
  output logic              rd_data,
  output logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] column,
  output logic              frame_done
);

  logic [N_COLS-1:0]  frame [N_ROWS];
  logic [BLINK_W-1:0] blink;
  logic [ROW_W-1:0]   scan;
  scan_state_t        state;
  logic               tick;
  logic               wr_in_range;
  logic [N_COLS-1:0]  cur_mask;

  matrix_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk   (CLOCK_50),
    .clear (rst || !en),
    .tick  (tick)
  );

  assign wr_in_range = (wr_row < ROW_W'(N_ROWS)) && (wr_col < COL_W'(N_COLS));
  assign rd_data     = wr_in_range ? frame[wr_row][wr_col] : 1'b0;

  always_comb begin
    cur_mask = '0;
    if (cur_en && blink[BLINK_BIT] && (cur_row == scan) &&
        (cur_row < ROW_W'(N_ROWS)) && (cur_col < COL_W'(N_COLS))) begin
      cur_mask = N_COLS'(1) << cur_col;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      blink <= '0;
    end else begin
      blink <= blink + BLINK_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst || clr) begin
      for (int r = 0; r < N_ROWS; r++) begin
        frame[r] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      frame[wr_row][wr_col] <= wr_data;
    end
  end

  // state tracks the prescaler phase: BLANK exactly while the count sits at 0
  always_ff @(posedge CLOCK_50) begin
    if (rst || !en) begin
      state      <= BLANK;
      scan       <= '0;
      row        <= '0;
      column     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (scan == ROW_W'(N_ROWS - 1));
      case (state)
        BLANK: begin
          row    <= '0;
          column <= '0;
          state  <= DRIVE;
        end
        default: begin
          row    <= row_onehot(scan);
          column <= frame[scan] | cur_mask;
          state  <= tick ? BLANK : DRIVE;
        end
      endcase
      if (tick) begin
        scan <= (scan == ROW_W'(N_ROWS - 1)) ? '0 : scan + ROW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// tb/tb_matrix_scan.sv - self-checking bench for matrix_scan with a slot-arithmetic reference model
module tb_matrix_scan;

  localparam int DIV = 4;
  localparam int BB  = 2;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b0, en = 1'b0, wr_en = 1'b0, wr_data = 1'b0, clr = 1'b0, cur_en = 1'b0;
  logic [2:0] wr_row = '0, wr_col = '0, cur_row = '0, cur_col = '0;
  logic       rd_data, frame_done;
  logic [4:0] row;
  logic [6:0] column;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  matrix_scan #(.SCAN_DIV(DIV), .BLINK_BIT(BB)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .clr        (clr),
    .cur_en     (cur_en),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .rd_data    (rd_data),
    .row        (row),
    .column     (column),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a display position is just the number of enabled cycles since scanning restarted
  bit         mframe [5][7];
  int         mn = 0;
  int         mblink = 0;
  int         m_pos, m_slot;
  bit         mvalid = 0;
  logic [4:0] e_row;
  logic [6:0] e_col;
  logic       e_fd;
  logic [6:0] m_mask;

  always @(posedge CLOCK_50) begin
    if (rst) begin
      e_row = '0; e_col = '0; e_fd = 1'b0;
      mn = 0; mblink = 0; mvalid = 1;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 7; c++) mframe[r][c] = 0;
    end else begin
      if (en) begin
        m_pos  = mn % DIV;
        m_slot = (mn / DIV) % 5;
        m_mask = '0;
        if (cur_en && ((mblink >> BB) & 1) == 1 && cur_row == m_slot && cur_row < 5 && cur_col < 7)
          m_mask[cur_col] = 1'b1;
        e_fd = (m_pos == DIV - 1) && (m_slot == 4);
        if (m_pos == 0) begin
          e_row = '0; e_col = '0;
        end else begin
          e_row = 5'(1 << m_slot);
          for (int c = 0; c < 7; c++) e_col[c] = mframe[m_slot][c] | m_mask[c];
        end
        mn++;
      end else begin
        e_row = '0; e_col = '0; e_fd = 1'b0; mn = 0;
      end
      if (clr) begin
        for (int r = 0; r < 5; r++) for (int c = 0; c < 7; c++) mframe[r][c] = 0;
      end else if (wr_en && wr_row < 5 && wr_col < 7) begin
        mframe[wr_row][wr_col] = wr_data;
      end
      mblink++;
    end
  end

  always @(negedge CLOCK_50) begin
    if (mvalid) begin
      check("row", 32'(row), 32'(e_row));
      check("column", 32'(column), 32'(e_col));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("rd_data", 32'(rd_data), (wr_row < 5 && wr_col < 7) ? 32'(mframe[wr_row][wr_col]) : 32'd0);
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic write_px(input int r, input int c, input bit d);
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int n_blank, n_fd, fd_first, fd_second, n_nz, n_on, n_off, n_other;
    bit found;

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_row", 32'(row), 32'd0);
    check("reset_column", 32'(column), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);

    write_px(0, 0, 1'b1);
    write_px(4, 6, 1'b1);
    write_px(5, 0, 1'b1);
    write_px(0, 7, 1'b1);
    wr_row = 3'd5; wr_col = 3'd0; #1;
    check("rd_oor_row", 32'(rd_data), 32'd0);
    wr_row = 3'd0; wr_col = 3'd7; #1;
    check("rd_oor_col", 32'(rd_data), 32'd0);
    wr_row = 3'd0; wr_col = 3'd0; #1;
    check("rd_00", 32'(rd_data), 32'd1);
    wr_row = 3'd4; wr_col = 3'd6; #1;
    check("rd_46", 32'(rd_data), 32'd1);

    en = 1'b1;
    n_blank = 0; n_fd = 0; fd_first = -1; fd_second = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (row == 5'd0) n_blank++;
      if (frame_done === 1'b1) begin
        n_fd++;
        if (fd_first < 0) fd_first = i; else if (fd_second < 0) fd_second = i;
      end
      if (i == 0) check("first_blank_row", 32'(row), 32'd0);
      if (i == 1) begin
        check("row0_drive_row", 32'(row), 32'b00001);
        check("row0_drive_col", 32'(column), 32'b0000001);
      end
      if (i == 5) begin
        check("row1_drive_row", 32'(row), 32'b00010);
        check("row1_drive_col", 32'(column), 32'd0);
      end
      if (i == 17) begin
        check("row4_drive_row", 32'(row), 32'b10000);
        check("row4_drive_col", 32'(column), 32'b1000000);
      end
      if (i == 18) check("fd_low_before_end", 32'(frame_done), 32'd0);
      if (i == 19) check("fd_at_row4_end", 32'(frame_done), 32'd1);
    end
    check("blank_cycles_40", 32'(n_blank), 32'd10);
    check("fd_pulses_40", 32'(n_fd), 32'd2);
    check("fd_period", 32'(fd_second - fd_first), 32'd20);

    for (int r = 0; r < 5; r++) for (int c = 0; c < 7; c++) write_px(r, c, 1'b1);
    clr = 1'b1; wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_data = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0;
    check("rd_11_after_clr", 32'(rd_data), 32'd0);
    step();
    n_nz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (column != 7'd0) n_nz++;
    end
    check("cols_zero_after_clr", 32'(n_nz), 32'd0);

    cur_en = 1'b1; cur_row = 3'd2; cur_col = 3'd3;
    n_on = 0; n_off = 0; n_other = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (row == 5'b00100) begin
        if (column == 7'b0001000) n_on++;
        else if (column == 7'd0) n_off++;
        else n_other++;
      end
    end
    check("cursor_seen_on", 32'(n_on > 0), 32'd1);
    check("cursor_seen_off", 32'(n_off > 0), 32'd1);
    check("cursor_other", 32'(n_other), 32'd0);
    cur_en = 1'b0;

    write_px(3, 2, 1'b1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (row == 5'b01000) found = 1;
    end
    check("row3_reached", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_row = 3'd3; wr_col = 3'd2; #1;
    check("midslot_rst_row", 32'(row), 32'd0);
    check("midslot_rst_col", 32'(column), 32'd0);
    check("midslot_rst_fd", 32'(frame_done), 32'd0);
    check("midslot_rst_buf", 32'(rd_data), 32'd0);

    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("en_low_out", 32'({row, column, frame_done}), 32'd0);
    end
    en = 1'b1;
    step();
    check("en_rise_blank", 32'(row), 32'd0);
    step();
    check("en_rise_row0", 32'(row), 32'b00001);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      en      = ($urandom_range(0, 19) != 0);
      clr     = ($urandom_range(0, 99) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_row  = 3'($urandom_range(0, 7));
      wr_col  = 3'($urandom_range(0, 7));
      wr_data = 1'($urandom);
      cur_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cur_row = 3'($urandom_range(0, 7));
        cur_col = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
